riscv_dmem_ctrl: RTL and testbench

Data-memory access controller between the load/store requesters and the data-memory/IO bridge (`riscv_io_bridge`). It arbitrates two requesters round-robin. It sequences each granted access onto the bridge's single-cycle read / posedge-write port. Byte and halfword stores become a read-modify-write of the full word, so the bridge only ever sees word writes. Load data is returned sign- or zero-extended. Misaligned requests are rejected without touching memory.

---
 rtl/riscv_dmem_ctrl_pkg.sv | 59 +++++
 rtl/riscv_dmem_ctrl_arb.sv | 31 +++
 rtl/riscv_dmem_ctrl.sv | 163 ++++++++++++++++
 tb/tb_riscv_dmem_ctrl.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_dmem_ctrl_pkg.sv
// Shared encodings and lane helpers for the data-memory access controller.
// Sub-word stores are merged here so the bridge only ever receives full words.
package riscv_dmem_ctrl_pkg;

    localparam logic [1:0] DMEM_SIZE_B = 2'b00;
    localparam logic [1:0] DMEM_SIZE_H = 2'b01;
    localparam logic [1:0] DMEM_SIZE_W = 2'b10;

    localparam int CACHE_D_WRITE_LEN = 2;
    localparam logic [CACHE_D_WRITE_LEN-1:0] CACHE_D_WRITE_SW = 2'b10;

    typedef enum logic [1:0] {
        DMEM_ST_IDLE = 2'd0,
        DMEM_ST_RD   = 2'd1,
        DMEM_ST_WR   = 2'd2,
        DMEM_ST_RESP = 2'd3
    } dmem_state_e;

    // Size code 11 is an alias for a full word.
    function automatic logic is_word(input logic [1:0] size);
        return (size == DMEM_SIZE_W) || (size == 2'b11);
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        return ((size == DMEM_SIZE_H) && off[0]) || (is_word(size) && (off != 2'b00));
    endfunction

    function automatic logic [31:0] merge_store(input logic [31:0] word,
                                                input logic [31:0] wdata,
                                                input logic [1:0]  size,
                                                input logic [1:0]  off);
        logic [31:0] merged;
        merged = word;
        case (size)
            DMEM_SIZE_B: merged[{off, 3'b000} +: 8]     = wdata[7:0];
            DMEM_SIZE_H: merged[{off[1], 4'b0000} +: 16] = wdata[15:0];
            default:     merged = wdata;
        endcase
        return merged;
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [1:0]  size,
                                                input logic [1:0]  off,
                                                input logic        uns);
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        logic [31:0] ext;
        lane_b = word[{off, 3'b000} +: 8];
        lane_h = word[{off[1], 4'b0000} +: 16];
        case (size)
            DMEM_SIZE_B: ext = uns ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
            DMEM_SIZE_H: ext = uns ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default:     ext = word;
        endcase
        return ext;
    endfunction

endpackage

// File: rtl/riscv_dmem_ctrl_arb.sv
// Two-way round-robin arbiter; the pointer names the port that wins a tie
// and moves to the other port whenever a grant is taken.
module riscv_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic ptr;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= 1'b0;
        end else if (advance && (gnt != 2'b00)) begin
            ptr <= gnt[0];
        end
    end

endmodule

// File: rtl/riscv_dmem_ctrl.sv
// Data-memory access controller: arbitrates two load/store ports and sequences
// each access onto the bridge as a single read, a word write, or read-modify-write.
module riscv_dmem_ctrl
    import riscv_dmem_ctrl_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NREQ-1:0]              req_valid,
    output logic [NREQ-1:0]              req_ready,
    input  logic [NREQ-1:0]              req_we,
    input  logic [2*NREQ-1:0]            req_size,
    input  logic [NREQ-1:0]              req_unsigned,
    input  logic [32*NREQ-1:0]           req_addr,
    input  logic [32*NREQ-1:0]           req_wdata,
    output logic [NREQ-1:0]              resp_valid,
    output logic [31:0]                  resp_rdata,
    output logic                         resp_err,
    output logic [31:0]                  mem_addr,
    output logic                         mem_write_en,
    output logic [CACHE_D_WRITE_LEN-1:0] mem_write_len,
    output logic [31:0]                  mem_wdata,
    input  logic [31:0]                  mem_rdata
);

    dmem_state_e state, state_next;

    logic [1:0]  gnt;
    logic        accept;
    logic        sel;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [1:0]  sel_size;
    logic        sel_we;
    logic        sel_uns;
    logic        sel_mis;

    logic        lat_port;
    logic        lat_we;
    logic        lat_uns;
    logic        lat_err;
    logic [1:0]  lat_size;
    logic [1:0]  lat_off;
    logic [15:0] lat_wdata;
    logic [31:0] rbuf;

    // Holding accept low while in reset keeps req_ready at zero during reset.
    assign accept = (state == DMEM_ST_IDLE) && rst && (gnt != 2'b00);

    riscv_rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid[1:0]),
        .advance (accept),
        .gnt     (gnt)
    );

    assign sel       = gnt[1];
    assign sel_addr  = req_addr[{sel, 5'b00000} +: 32];
    assign sel_wdata = req_wdata[{sel, 5'b00000} +: 32];
    assign sel_size  = req_size[{sel, 1'b0} +: 2];
    assign sel_we    = req_we[sel];
    assign sel_uns   = req_unsigned[sel];
    assign sel_mis   = is_misaligned(sel_size, sel_addr[1:0]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= DMEM_ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = '0;
        case (state)
            DMEM_ST_IDLE: begin
                if (accept) begin
                    req_ready = gnt;
                    if (sel_mis) begin
                        state_next = DMEM_ST_RESP;
                    end else if (sel_we && is_word(sel_size)) begin
                        state_next = DMEM_ST_WR;
                    end else begin
                        state_next = DMEM_ST_RD;
                    end
                end
            end
            DMEM_ST_RD:   state_next = lat_we ? DMEM_ST_WR : DMEM_ST_RESP;
            DMEM_ST_WR:   state_next = DMEM_ST_RESP;
            default:      state_next = DMEM_ST_IDLE;
        endcase
    end

    // Bridge signals are registered one state ahead, so they are already valid
    // throughout the RD/WR cycle they belong to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_port      <= 1'b0;
            lat_we        <= 1'b0;
            lat_uns       <= 1'b0;
            lat_err       <= 1'b0;
            lat_size      <= 2'b00;
            lat_off       <= 2'b00;
            lat_wdata     <= 16'd0;
            rbuf          <= 32'd0;
            mem_addr      <= 32'd0;
            mem_write_en  <= 1'b0;
            mem_write_len <= '0;
            mem_wdata     <= 32'd0;
        end else begin
            mem_write_en  <= 1'b0;
            mem_write_len <= '0;
            case (state)
                DMEM_ST_IDLE: begin
                    if (accept) begin
                        lat_port  <= sel;
                        lat_we    <= sel_we;
                        lat_uns   <= sel_uns;
                        lat_err   <= sel_mis;
                        lat_size  <= sel_size;
                        lat_off   <= sel_addr[1:0];
                        lat_wdata <= sel_wdata[15:0];
                        if (!sel_mis) begin
                            mem_addr <= {sel_addr[31:2], 2'b00};
                            if (sel_we && is_word(sel_size)) begin
                                mem_write_en  <= 1'b1;
                                mem_write_len <= CACHE_D_WRITE_SW;
                                mem_wdata     <= sel_wdata;
                            end
                        end
                    end
                end
                DMEM_ST_RD: begin
                    rbuf <= mem_rdata;
                    if (lat_we) begin
                        mem_write_en  <= 1'b1;
                        mem_write_len <= CACHE_D_WRITE_SW;
                        mem_wdata     <= merge_store(mem_rdata, {16'd0, lat_wdata}, lat_size, lat_off);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        resp_valid = '0;
        resp_err   = 1'b0;
        resp_rdata = 32'd0;
        if (state == DMEM_ST_RESP) begin
            resp_valid[lat_port] = 1'b1;
            resp_err             = lat_err;
            if (!lat_we && !lat_err) begin
                resp_rdata = extend_load(rbuf, lat_size, lat_off, lat_uns);
            end
        end
    end

endmodule

// File: tb/tb_riscv_dmem_ctrl.sv
// Self-checking bench for riscv_dmem_ctrl with a behavioural bridge and a
// word-array reference model of memory contents, load extension and timing.
module tb_riscv_dmem_ctrl;
    import riscv_dmem_ctrl_pkg::*;

    localparam logic [31:0] LED_ADDR = 32'hFFFFFC04;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_we;
    logic [3:0]  req_size;
    logic [1:0]  req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_write_en;
    logic [1:0]  mem_write_len;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks;
    int errors;

    logic [31:0] bmem [64];
    logic [31:0] ref_mem [64];
    logic [31:0] led;
    int          wr_events;

    int          obs_resp_cyc;
    logic [1:0]  obs_resp_port;
    logic [31:0] obs_rdata;
    logic        obs_err;
    int          obs_wr_cyc;
    int          obs_wr_cnt;
    logic [31:0] obs_wr_data;
    logic [31:0] obs_wr_addr;
    logic [1:0]  obs_wr_len;
    logic [31:0] obs_addr_c1;
    logic        obs_we_c1;
    logic [1:0]  obs_ready;

    riscv_dmem_ctrl #(.NREQ(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_size      (req_size),
        .req_unsigned  (req_unsigned),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .mem_addr      (mem_addr),
        .mem_write_en  (mem_write_en),
        .mem_write_len (mem_write_len),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = (mem_addr == LED_ADDR) ? led : bmem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_write_en) begin
            wr_events = wr_events + 1;
            if (mem_addr == LED_ADDR) led = mem_wdata;
            else bmem[mem_addr[7:2]] = mem_wdata;
        end
    end

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] size,
                                             input logic [1:0] off, input logic uns);
        logic [31:0] v;
        int sh;
        sh = 8 * int'(off);
        if (size == 2'd0) begin
            v = (word >> sh) & 32'h000000FF;
            if (!uns && v[7]) v = v | 32'hFFFFFF00;
        end else if (size == 2'd1) begin
            v = (word >> sh) & 32'h0000FFFF;
            if (!uns && v[15]) v = v | 32'hFFFF0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] word, input logic [31:0] wdata,
                                              input logic [1:0] size, input logic [1:0] off);
        logic [31:0] mask;
        int sh;
        sh = 8 * int'(off);
        if (size >= 2'd2) return wdata;
        mask = ((size == 2'd0) ? 32'h000000FF : 32'h0000FFFF) << sh;
        return (word & ~mask) | ((wdata << sh) & mask);
    endfunction

    function automatic logic ref_mis(input logic [1:0] size, input logic [1:0] off);
        return ((size == 2'd1) && (off % 2 != 0)) || ((size >= 2'd2) && (off != 2'd0));
    endfunction

    task automatic do_access(input int port, input logic we, input logic [1:0] size,
                             input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        req_valid                = 2'b00;
        req_valid[port]          = 1'b1;
        req_we[port]             = we;
        req_size[2*port +: 2]    = size;
        req_unsigned[port]       = uns;
        req_addr[32*port +: 32]  = addr;
        req_wdata[32*port +: 32] = wdata;
        #1;
        obs_ready = req_ready;
        @(posedge clk);
        obs_resp_cyc = 0; obs_resp_port = 2'b00; obs_rdata = 32'hDEAD; obs_err = 1'bx;
        obs_wr_cyc = 0; obs_wr_cnt = 0; obs_wr_data = 32'd0; obs_wr_addr = 32'd0; obs_wr_len = 2'b00;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req_valid = 2'b00;
                req_addr  = {$urandom, $urandom};
                req_wdata = {$urandom, $urandom};
                obs_addr_c1 = mem_addr;
                obs_we_c1   = mem_write_en;
            end
            if (mem_write_en) begin
                obs_wr_cnt++; obs_wr_cyc = c; obs_wr_data = mem_wdata;
                obs_wr_addr = mem_addr; obs_wr_len = mem_write_len;
            end
            if (resp_valid != 2'b00) begin
                obs_resp_cyc = c; obs_resp_port = resp_valid;
                obs_rdata = resp_rdata; obs_err = resp_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req_valid = 2'b11; req_we = 2'b11; req_size = 4'b1010; req_unsigned = 2'b00;
        req_addr = 64'h0000_0010_0000_0000; req_wdata = {$urandom, $urandom};
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({req_ready, resp_valid, resp_err, mem_write_en, mem_write_len} !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl got %b exp 0", {req_ready, resp_valid, resp_err, mem_write_en, mem_write_len});
        end
        checks++;
        if ({resp_rdata, mem_addr, mem_wdata} !== 96'd0) begin
            errors++;
            $display("[TB] FAIL reset_data got %h exp 0", {resp_rdata, mem_addr, mem_wdata});
        end
        @(negedge clk);
        req_valid = 2'b00;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int g_port[$]; int g_cyc[$]; int r_port[$]; int r_cyc[$]; logic [31:0] r_data[$];
        logic [31:0] exp0, exp1, expd;
        exp0 = ref_load(ref_mem[16], 2'd2, 2'd0, 1'b0);
        exp1 = ref_load(ref_mem[17], 2'd0, 2'd1, 1'b1);
        @(negedge clk);
        req_valid = 2'b11; req_we = 2'b00; req_size = 4'b0010; req_unsigned = 2'b10;
        req_addr = {32'h00000045, 32'h00000040};
        for (int c = 0; c <= 21; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 17) req_valid = 2'b00;
            #1;
            if (req_ready != 2'b00) begin g_port.push_back(req_ready[1] ? 1 : 0); g_cyc.push_back(c); end
            if (resp_valid != 2'b00) begin
                r_port.push_back(resp_valid == 2'b10 ? 1 : (resp_valid == 2'b01 ? 0 : 9));
                r_cyc.push_back(c); r_data.push_back(resp_rdata);
            end
        end
        checks++;
        if (g_port.size() != 6 || r_port.size() != 6) begin
            errors++;
            $display("[TB] FAIL b2b_count got %0d/%0d exp 6/6", g_port.size(), r_port.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                expd = (i % 2 == 0) ? exp0 : exp1;
                checks++;
                if (g_port[i] != i % 2 || g_cyc[i] != 3 * i) begin
                    errors++;
                    $display("[TB] FAIL b2b_grant%0d got port %0d cyc %0d exp port %0d cyc %0d", i, g_port[i], g_cyc[i], i % 2, 3 * i);
                end
                checks++;
                if (r_port[i] != i % 2 || r_cyc[i] != 3 * i + 2 || r_data[i] !== expd) begin
                    errors++;
                    $display("[TB] FAIL b2b_resp%0d got port %0d cyc %0d data %h exp port %0d cyc %0d data %h",
                             i, r_port[i], r_cyc[i], r_data[i], i % 2, 3 * i + 2, expd);
                end
            end
        end
    endtask

    task automatic test_lb_lbu();
        ref_mem[0] = 32'h80FF1234; bmem[0] = 32'h80FF1234;
        do_access(0, 1'b0, 2'b00, 1'b0, 32'h00000003, 32'd0);
        checks++;
        if (obs_ready !== 2'b01) begin errors++; $display("[TB] FAIL lb_ready got %b exp 01", obs_ready); end
        checks++;
        if (obs_resp_cyc != 2 || obs_resp_port !== 2'b01 || obs_rdata !== 32'hFFFFFF80 || obs_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lb got cyc %0d port %b data %h err %b exp cyc 2 port 01 data ffffff80 err 0",
                     obs_resp_cyc, obs_resp_port, obs_rdata, obs_err);
        end
        do_access(0, 1'b0, 2'b00, 1'b1, 32'h00000003, 32'd0);
        checks++;
        if (obs_resp_cyc != 2 || obs_rdata !== 32'h00000080) begin
            errors++;
            $display("[TB] FAIL lbu got cyc %0d data %h exp cyc 2 data 00000080", obs_resp_cyc, obs_rdata);
        end
    endtask

    task automatic test_sh_rmw();
        ref_mem[4] = 32'h11223344; bmem[4] = 32'h11223344;
        do_access(1, 1'b1, 2'b01, 1'b0, 32'h00000012, 32'h1234BEEF);
        ref_mem[4] = ref_store(ref_mem[4], 32'h1234BEEF, 2'd1, 2'd2);
        checks++;
        if (obs_addr_c1 !== 32'h00000010 || obs_we_c1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sh_read got addr %h we %b exp addr 00000010 we 0", obs_addr_c1, obs_we_c1);
        end
        checks++;
        if (obs_wr_cnt != 1 || obs_wr_cyc != 2 || obs_wr_data !== 32'hBEEF3344 || obs_wr_len !== CACHE_D_WRITE_SW) begin
            errors++;
            $display("[TB] FAIL sh_write got n %0d cyc %0d data %h len %b exp n 1 cyc 2 data beef3344 len 10",
                     obs_wr_cnt, obs_wr_cyc, obs_wr_data, obs_wr_len);
        end
        checks++;
        if (obs_resp_cyc != 3 || obs_resp_port !== 2'b10 || obs_rdata !== 32'd0) begin
            errors++;
            $display("[TB] FAIL sh_resp got cyc %0d port %b data %h exp cyc 3 port 10 data 0", obs_resp_cyc, obs_resp_port, obs_rdata);
        end
    endtask

    task automatic test_misaligned();
        do_access(0, 1'b1, 2'b10, 1'b0, 32'h00000006, 32'hCAFEF00D);
        checks++;
        if (obs_resp_cyc != 1 || obs_err !== 1'b1 || obs_wr_cnt != 0 || obs_rdata !== 32'd0) begin
            errors++;
            $display("[TB] FAIL sw_misaligned got cyc %0d err %b writes %0d data %h exp cyc 1 err 1 writes 0 data 0",
                     obs_resp_cyc, obs_err, obs_wr_cnt, obs_rdata);
        end
        do_access(1, 1'b0, 2'b01, 1'b0, 32'h00000005, 32'd0);
        checks++;
        if (obs_resp_cyc != 1 || obs_err !== 1'b1 || obs_resp_port !== 2'b10 || obs_rdata !== 32'd0) begin
            errors++;
            $display("[TB] FAIL lh_misaligned got cyc %0d err %b port %b data %h exp cyc 1 err 1 port 10 data 0",
                     obs_resp_cyc, obs_err, obs_resp_port, obs_rdata);
        end
    endtask

    task automatic test_led_store();
        do_access(0, 1'b1, 2'b10, 1'b0, LED_ADDR, 32'h00ABCDEF);
        checks++;
        if (obs_wr_cyc != 1 || obs_wr_addr !== LED_ADDR || obs_resp_cyc != 2) begin
            errors++;
            $display("[TB] FAIL sw_timing got wcyc %0d addr %h rcyc %0d exp wcyc 1 addr fffffc04 rcyc 2",
                     obs_wr_cyc, obs_wr_addr, obs_resp_cyc);
        end
        checks++;
        if (led !== 32'h00ABCDEF) begin errors++; $display("[TB] FAIL led got %h exp 00abcdef", led); end
    endtask

    task automatic test_random();
        int port; logic we; logic [1:0] size; logic uns; logic [31:0] addr, wdata;
        logic [31:0] exp_rdata, exp_wdata; int exp_resp, exp_wr_cyc; logic exp_err; int idx;
        for (int n = 0; n < 40; n++) begin
            port = $urandom_range(0, 1); we = 1'($urandom); size = 2'($urandom); uns = 1'($urandom);
            addr = 32'($urandom_range(0, 255)); wdata = $urandom;
            idx = int'(addr[7:2]);
            exp_err = ref_mis(size, addr[1:0]); exp_rdata = 32'd0; exp_wr_cyc = 0; exp_wdata = 32'd0;
            if (exp_err) exp_resp = 1;
            else if (we) begin
                exp_wr_cyc = (size >= 2'd2) ? 1 : 2; exp_resp = exp_wr_cyc + 1;
                exp_wdata = ref_store(ref_mem[idx], wdata, size, addr[1:0]);
            end else begin
                exp_resp = 2; exp_rdata = ref_load(ref_mem[idx], size, addr[1:0], uns);
            end
            do_access(port, we, size, uns, addr, wdata);
            if (exp_wr_cyc != 0) ref_mem[idx] = exp_wdata;
            checks++;
            if (obs_resp_cyc != exp_resp || obs_resp_port !== (2'b01 << port) || obs_err !== exp_err || obs_rdata !== exp_rdata) begin
                errors++;
                $display("[TB] FAIL rand%0d_resp got cyc %0d port %b err %b data %h exp cyc %0d port %0d err %b data %h",
                         n, obs_resp_cyc, obs_resp_port, obs_err, obs_rdata, exp_resp, port, exp_err, exp_rdata);
            end
            checks++;
            if (obs_wr_cnt != (exp_wr_cyc != 0 ? 1 : 0) || obs_wr_cyc != exp_wr_cyc ||
                (exp_wr_cyc != 0 && (obs_wr_data !== exp_wdata || obs_wr_addr !== {addr[31:2], 2'b00} || obs_wr_len !== CACHE_D_WRITE_SW))) begin
                errors++;
                $display("[TB] FAIL rand%0d_write got n %0d cyc %0d data %h addr %h exp cyc %0d data %h addr %h",
                         n, obs_wr_cnt, obs_wr_cyc, obs_wr_data, obs_wr_addr, exp_wr_cyc, exp_wdata, {addr[31:2], 2'b00});
            end
        end
    endtask

    task automatic test_reset_mid_rmw();
        int ev0; int bad_we; int bad_resp;
        ev0 = wr_events; bad_we = 0; bad_resp = 0;
        @(negedge clk);
        req_valid = 2'b01; req_we = 2'b01; req_size = 4'b0000; req_unsigned = 2'b00;
        req_addr = {32'h0, 32'h00000021}; req_wdata = {32'h0, 32'h0000005A};
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; req_valid = 2'b00;
        #1;
        checks++;
        if ({resp_valid, mem_write_en, req_ready} !== 5'd0 || mem_addr !== 32'd0) begin
            errors++;
            $display("[TB] FAIL rst_mid_outputs got %b addr %h exp 0", {resp_valid, mem_write_en, req_ready}, mem_addr);
        end
        repeat (2) begin
            @(negedge clk);
            if (mem_write_en) bad_we++;
            if (resp_valid != 2'b00) bad_resp++;
        end
        rst = 1'b1;
        req_valid = 2'b11; req_we = 2'b00; req_size = 4'b1010;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin errors++; $display("[TB] FAIL rst_first_grant got %b exp 01", req_ready); end
        req_valid = 2'b00;
        repeat (3) begin
            @(negedge clk);
            if (mem_write_en) bad_we++;
            if (resp_valid != 2'b00) bad_resp++;
        end
        checks++;
        if (bad_we != 0 || bad_resp != 0 || wr_events != ev0 || bmem[8] !== ref_mem[8]) begin
            errors++;
            $display("[TB] FAIL rst_dropped got we %0d resp %0d writes %0d word %h exp 0 0 %0d %h",
                     bad_we, bad_resp, wr_events, bmem[8], ev0, ref_mem[8]);
        end
        do_access(1, 1'b0, 2'b10, 1'b0, 32'h00000020, 32'd0);
        checks++;
        if (obs_resp_cyc != 2 || obs_rdata !== ref_mem[8]) begin
            errors++;
            $display("[TB] FAIL rst_recover got cyc %0d data %h exp cyc 2 data %h", obs_resp_cyc, obs_rdata, ref_mem[8]);
        end
    endtask

    initial begin
        checks = 0; errors = 0; wr_events = 0; led = 32'd0;
        for (int i = 0; i < 64; i++) begin ref_mem[i] = $urandom; bmem[i] = ref_mem[i]; end
        test_reset();
        test_back_to_back();
        test_lb_lbu();
        test_sh_rmw();
        test_misaligned();
        test_led_store();
        test_random();
        test_reset_mid_rmw();
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (bmem[i] !== ref_mem[i]) begin
                errors++;
                $display("[TB] FAIL mem_word%0d got %h exp %h", i, bmem[i], ref_mem[i]);
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
